q3_stim_driver: RTL and testbench
=================================

Q3_STIM_DRIVER -- requirements
Module: q3_stim_driver

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the window and error counters.
REQ-002 SHALL have input clk, 1 bit, the rising-edge clock for all state.
REQ-003 SHALL have input reset, 1 bit, a synchronous active-high reset.
REQ-004 SHALL have input en, 1 bit, which requests stream start and is sampled only in IDLE.
REQ-005 SHALL have input pat_valid, 1 bit, meaning a window pattern is offered.
REQ-006 SHALL have input pat_data, 3 bits, the window pattern; bit0 is sent first.
REQ-007 SHALL have output pat_ready, 1 bit, meaning the driver accepts a pattern this cycle.
REQ-008 SHALL have output s_out, 1 bit, the start strobe to the 3-bit-window detector.
REQ-009 SHALL have output w_out, 1 bit, the serial window bit to the detector.
REQ-010 SHALL have input z_in, 1 bit, the detector's combinational "exactly two of three" flag.
REQ-011 SHALL have output res_valid, 1 bit, a one-cycle pulse marking a checked window result.
REQ-012 SHALL have output res_z, 1 bit, the sampled z_in for the checked window.
REQ-013 SHALL have output res_err, 1 bit, set when res_z differs from the expected value.
REQ-014 SHALL have output win_cnt, CNT_W bits, counting checked (non-filler) windows.
REQ-015 SHALL have output err_cnt, CNT_W bits, counting mismatches.

Function
REQ-016 SHALL implement FSM states IDLE, START, BIT0, BIT1, BIT2.
REQ-017 SHALL define transitions: IDLE->START when en=1, else stay IDLE; START->BIT0; BIT0->BIT1; BIT1->BIT2; BIT2->BIT0 unconditionally.
REQ-018 SHALL keep streaming until reset once started, because the detector never returns to its idle state; en is ignored outside IDLE.
REQ-019 SHALL drive s_out=1 only in START and 0 in all other states.
REQ-020 SHALL drive w_out=0 in IDLE/START, cur[0] in BIT0, cur[1] in BIT1 and cur[2] in BIT2.
REQ-021 SHALL assert pat_ready combinationally in START and BIT2 only.
REQ-022 SHALL, at a clock edge with pat_ready&pat_valid, load cur<=pat_data, cur_real<=1 and cur_exp<=(popcount(pat_data)==2).
REQ-023 SHALL, at a pat_ready edge without pat_valid, load the filler cur<=3'b000 with cur_real<=0 and cur_exp<=0.
REQ-024 SHALL copy cur_real/cur_exp into pend_real/pend_exp at the BIT2->BIT0 edge, because the detector presents z for a window during the next window's BIT0 cycle.
REQ-025 SHALL, at the edge ending each BIT0 that follows a completed window and when pend_real=1, register res_valid=1, res_z=z_in and res_err=(z_in!=pend_exp) for exactly one cycle.
REQ-026 SHALL sample nothing in the first BIT0 after START, since no window is pending; pend_real SHALL be 0 there.
REQ-027 SHALL hold res_valid=0 for filler windows and leave res_z/res_err holding their last values.
REQ-028 SHALL increment win_cnt on each res_valid and err_cnt on each res_err, both saturating at all-ones with no wrap.
REQ-029 SHALL, when pat_data is offered in BIT2 simultaneously with a z sample pending, process both independently.

Reset
REQ-030 SHALL, on reset=1 at a clock edge, set state=IDLE, cur=0, cur_real=0, pend_real=0, res_valid=0, res_z=0, res_err=0, win_cnt=0 and err_cnt=0; s_out=0 and w_out=0 follow.
REQ-031 SHALL treat reset mid-stream as discarding any pending or in-flight window without reporting it; the detector is reset by the same signal.
REQ-032 SHALL give reset priority over en and pat_valid in the same cycle.

Verification
REQ-033 SHALL cover single window: cycle0 IDLE with en=1, cycle1 START with pat 3'b011, then no patterns -> w_out=1,1,0 in cycles 2-4; cycle6 res_valid=1, res_z=1, res_err=0, win_cnt=1.
REQ-034 SHALL cover back-to-back patterns 3'b111, 3'b101, 3'b001 -> res_z=0,1,0, err_cnt=0, win_cnt=3, with no filler between windows.
REQ-035 SHALL cover a fault in which z_in is forced to 0 with pattern 3'b110 -> res_err=1, err_cnt=1.
REQ-036 SHALL cover filler: no pat_valid for 4 windows -> w_out stays 0 and res_valid never pulses.
REQ-037 SHALL cover reset asserted in BIT1 of window 2 -> IDLE next cycle, counters 0, no res_valid; restart with en then behaves as in REQ-033.
REQ-038 SHALL cover saturation with CNT_W=2 and 5 mismatching windows -> err_cnt stays at 3.

Source files
------------

// File: rtl/q3_stim_driver.sv
// Stimulus driver and checker for a 3-bit-window "exactly two of three" detector.
// Streams one window per three cycles and scores the detector's answer one window later.
module q3_stim_driver #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             pat_valid,
    input  logic [2:0]       pat_data,
    output logic             pat_ready,
    output logic             s_out,
    output logic             w_out,
    input  logic             z_in,
    output logic             res_valid,
    output logic             res_z,
    output logic             res_err,
    output logic [CNT_W-1:0] win_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT0,
        BIT1,
        BIT2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         cur_q, cur_d;
    logic               cur_real_q, cur_real_d;
    logic               cur_exp_q, cur_exp_d;
    logic               pend_real_q, pend_real_d;
    logic               pend_exp_q, pend_exp_d;
    logic               res_valid_q, res_valid_d;
    logic               res_z_q, res_z_d;
    logic               res_err_q, res_err_d;
    logic [CNT_W-1:0]   win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               pat_two_ones;

    assign pat_two_ones = (pat_data == 3'b011) || (pat_data == 3'b101) || (pat_data == 3'b110);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_q       <= 3'b000;
            cur_real_q  <= 1'b0;
            cur_exp_q   <= 1'b0;
            pend_real_q <= 1'b0;
            pend_exp_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_z_q     <= 1'b0;
            res_err_q   <= 1'b0;
            win_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            cur_real_q  <= cur_real_d;
            cur_exp_q   <= cur_exp_d;
            pend_real_q <= pend_real_d;
            pend_exp_q  <= pend_exp_d;
            res_valid_q <= res_valid_d;
            res_z_q     <= res_z_d;
            res_err_q   <= res_err_d;
            win_cnt_q   <= win_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        cur_real_d  = cur_real_q;
        cur_exp_d   = cur_exp_q;
        pend_real_d = pend_real_q;
        pend_exp_d  = pend_exp_q;
        res_valid_d = 1'b0;
        res_z_d     = res_z_q;
        res_err_d   = res_err_q;
        win_cnt_d   = win_cnt_q;
        err_cnt_d   = err_cnt_q;
        pat_ready   = 1'b0;
        s_out       = 1'b0;
        w_out       = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) state_d = START;
            end
            START: begin
                s_out     = 1'b1;
                pat_ready = 1'b1;
                state_d   = BIT0;
            end
            BIT0: begin
                // The detector's answer for the previous window is visible only now.
                w_out       = cur_q[0];
                state_d     = BIT1;
                res_valid_d = pend_real_q;
                if (pend_real_q) begin
                    res_z_d   = z_in;
                    res_err_d = (z_in != pend_exp_q);
                    if (win_cnt_q != {CNT_W{1'b1}}) win_cnt_d = win_cnt_q + CNT_W'(1);
                    if ((z_in != pend_exp_q) && (err_cnt_q != {CNT_W{1'b1}}))
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                end
            end
            BIT1: begin
                w_out   = cur_q[1];
                state_d = BIT2;
            end
            BIT2: begin
                w_out       = cur_q[2];
                pat_ready   = 1'b1;
                pend_real_d = cur_real_q;
                pend_exp_d  = cur_exp_q;
                state_d     = BIT0;
            end
            default: state_d = IDLE;
        endcase

        // A missing pattern becomes an all-zero filler window that is never scored.
        if (pat_ready) begin
            cur_d      = pat_valid ? pat_data : 3'b000;
            cur_real_d = pat_valid;
            cur_exp_d  = pat_valid && pat_two_ones;
        end
    end

    assign res_valid = res_valid_q;
    assign res_z     = res_z_q;
    assign res_err   = res_err_q;
    assign win_cnt   = win_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_q3_stim_driver.sv
// Self-checking bench for q3_stim_driver with a behavioural window detector stub
// and a cycle-level reference model built from window schedules and result queues.
module tb_q3_stim_driver;

    logic        clk = 1'b0;
    logic        reset, en, pat_valid, z_in;
    logic [2:0]  pat_data;
    logic        pat_ready, s_out, w_out, res_valid, res_z, res_err;
    logic [15:0] win_cnt, err_cnt;
    logic        satReady, satS, satW, satRv, satZ, satErr;
    logic [1:0]  satWin, satErrCnt;

    always #5 clk = ~clk;

    q3_stim_driver #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .en(en), .pat_valid(pat_valid), .pat_data(pat_data),
        .pat_ready(pat_ready), .s_out(s_out), .w_out(w_out), .z_in(z_in),
        .res_valid(res_valid), .res_z(res_z), .res_err(res_err),
        .win_cnt(win_cnt), .err_cnt(err_cnt)
    );

    q3_stim_driver #(.CNT_W(2)) dutSat (
        .clk(clk), .reset(reset), .en(en), .pat_valid(pat_valid), .pat_data(pat_data),
        .pat_ready(satReady), .s_out(satS), .w_out(satW), .z_in(z_in),
        .res_valid(satRv), .res_z(satZ), .res_err(satErr),
        .win_cnt(satWin), .err_cnt(satErrCnt)
    );

    // Detector stub: starts on s_out, gathers three bits, presents its flag from the next cycle.
    logic       detActive, detZ;
    logic [1:0] detCnt, detBits;
    bit         forceZ0 = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            detActive <= 1'b0;
            detCnt    <= 2'd0;
            detBits   <= 2'b00;
            detZ      <= 1'b0;
        end else if (s_out) begin
            detActive <= 1'b1;
            detCnt    <= 2'd0;
        end else if (detActive) begin
            if (detCnt == 2'd2) begin
                detZ   <= ($countones({w_out, detBits}) == 2);
                detCnt <= 2'd0;
            end else begin
                detBits <= {w_out, detBits[1]};
                detCnt  <= detCnt + 2'd1;
            end
        end
    end

    assign z_in = forceZ0 ? 1'b0 : detZ;

    typedef struct {
        int due;
        bit z;
        bit err;
    } res_t;

    int         cyc = 0;
    bit         streaming = 1'b0;
    int         startCyc = 0;
    logic [2:0] winQ[$];
    res_t       resQ[$];
    int         winCnt = 0, errCnt = 0;
    logic       lastZ = 1'b0, lastErr = 1'b0;
    logic       expReady, expS, expW, expRv, expZ, expErr;
    int         nRun = 0, nFail = 0;

    // Derives this cycle's expected outputs from the stream schedule and result queue.
    task automatic modelOutputs();
        int rel, idx;
        expS     = streaming && (cyc == startCyc);
        expReady = streaming && (cyc >= startCyc) && (((cyc - startCyc) % 3) == 0);
        expW     = 1'b0;
        if (streaming && cyc > startCyc) begin
            rel = cyc - startCyc - 1;
            idx = rel / 3;
            if (idx < winQ.size()) expW = winQ[idx][rel % 3];
        end
        expRv = 1'b0;
        if (resQ.size() > 0 && resQ[0].due == cyc) begin
            expRv   = 1'b1;
            lastZ   = resQ[0].z;
            lastErr = resQ[0].err;
            if (winCnt < 65535) winCnt++;
            if (resQ[0].err && errCnt < 65535) errCnt++;
            void'(resQ.pop_front());
        end
        expZ   = lastZ;
        expErr = lastErr;
    endtask

    task automatic advance();
        bit two, zz;
        if (reset) begin
            streaming = 1'b0;
            winQ.delete();
            resQ.delete();
            winCnt  = 0;
            errCnt  = 0;
            lastZ   = 1'b0;
            lastErr = 1'b0;
        end else if (!streaming && en) begin
            streaming = 1'b1;
            startCyc  = cyc + 1;
        end else if (expReady) begin
            if (pat_valid) begin
                winQ.push_back(pat_data);
                two = ($countones(pat_data) == 2);
                zz  = forceZ0 ? 1'b0 : two;
                resQ.push_back('{cyc + 5, zz, zz != two});
            end else begin
                winQ.push_back(3'b000);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic doReset(input bit withInputs);
        reset     = 1'b1;
        en        = withInputs;
        pat_valid = withInputs;
        pat_data  = 3'b110;
        modelOutputs();
        advance();
        reset     = 1'b0;
        en        = 1'b0;
        pat_valid = 1'b0;
    endtask

    task automatic test_reset();
        doReset(1'b1);
        for (int i = 0; i < 3; i++) begin
            modelOutputs();
            nRun++;
            if ({pat_ready, s_out, w_out, res_valid, res_z, res_err} !== 6'b000000) begin
                nFail++;
                $display("[TB] FAIL reset_ctl cyc=%0d got %b want 000000", cyc,
                         {pat_ready, s_out, w_out, res_valid, res_z, res_err});
            end
            nRun++;
            if (win_cnt !== 16'd0 || err_cnt !== 16'd0 || satErrCnt !== 2'd0) begin
                nFail++;
                $display("[TB] FAIL reset_cnt got win=%0d err=%0d satErr=%0d want 0", win_cnt, err_cnt, satErrCnt);
            end
            advance();
        end
    endtask

    task automatic test_single_window();
        doReset(1'b0);
        for (int i = 0; i < 10; i++) begin
            en = (i == 0); pat_valid = (i == 1); pat_data = 3'b011;
            modelOutputs();
            nRun++;
            if ({pat_ready, s_out, w_out, res_valid, res_z, res_err} !== {expReady, expS, expW, expRv, expZ, expErr}) begin
                nFail++;
                $display("[TB] FAIL single_ctl cyc=%0d got %b want %b", i,
                         {pat_ready, s_out, w_out, res_valid, res_z, res_err}, {expReady, expS, expW, expRv, expZ, expErr});
            end
            nRun++;
            if (win_cnt !== 16'(winCnt) || err_cnt !== 16'(errCnt)) begin
                nFail++;
                $display("[TB] FAIL single_cnt cyc=%0d got %0d/%0d want %0d/%0d", i, win_cnt, err_cnt, winCnt, errCnt);
            end
            if (i == 6) begin
                nRun++;
                if ({res_valid, res_z, res_err} !== 3'b110 || win_cnt !== 16'd1) begin
                    nFail++;
                    $display("[TB] FAIL single_result got v/z/e=%b win=%0d want 110 win=1", {res_valid, res_z, res_err}, win_cnt);
                end
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] pats [3];
        pats = '{3'b111, 3'b101, 3'b001};
        doReset(1'b0);
        for (int i = 0; i < 16; i++) begin
            en = (i == 0);
            pat_valid = (i == 1 || i == 4 || i == 7);
            pat_data  = (i == 1) ? pats[0] : (i == 4) ? pats[1] : pats[2];
            modelOutputs();
            nRun++;
            if ({pat_ready, s_out, w_out, res_valid, res_z, res_err} !== {expReady, expS, expW, expRv, expZ, expErr}) begin
                nFail++;
                $display("[TB] FAIL b2b_ctl cyc=%0d got %b want %b", i,
                         {pat_ready, s_out, w_out, res_valid, res_z, res_err}, {expReady, expS, expW, expRv, expZ, expErr});
            end
            advance();
        end
        nRun++;
        if (win_cnt !== 16'd3 || err_cnt !== 16'd0 || res_z !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL b2b_final got win=%0d err=%0d z=%b want win=3 err=0 z=0", win_cnt, err_cnt, res_z);
        end
    endtask

    task automatic test_fault();
        forceZ0 = 1'b1;
        doReset(1'b0);
        for (int i = 0; i < 9; i++) begin
            en = (i == 0); pat_valid = (i == 1); pat_data = 3'b110;
            modelOutputs();
            nRun++;
            if ({pat_ready, s_out, w_out, res_valid, res_z, res_err} !== {expReady, expS, expW, expRv, expZ, expErr}) begin
                nFail++;
                $display("[TB] FAIL fault_ctl cyc=%0d got %b want %b", i,
                         {pat_ready, s_out, w_out, res_valid, res_z, res_err}, {expReady, expS, expW, expRv, expZ, expErr});
            end
            if (i == 6) begin
                nRun++;
                if ({res_valid, res_z, res_err} !== 3'b101 || err_cnt !== 16'd1) begin
                    nFail++;
                    $display("[TB] FAIL fault_result got v/z/e=%b err=%0d want 101 err=1", {res_valid, res_z, res_err}, err_cnt);
                end
            end
            advance();
        end
        forceZ0 = 1'b0;
    endtask

    task automatic test_filler();
        doReset(1'b0);
        for (int i = 0; i < 17; i++) begin
            en = (i == 0); pat_valid = 1'b0; pat_data = 3'b111;
            modelOutputs();
            nRun++;
            if ({pat_ready, s_out, w_out, res_valid} !== {expReady, expS, expW, expRv} || w_out !== 1'b0 || res_valid !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL filler_ctl cyc=%0d got %b want %b", i,
                         {pat_ready, s_out, w_out, res_valid}, {expReady, expS, expW, expRv});
            end
            advance();
        end
        nRun++;
        if (win_cnt !== 16'd0) begin
            nFail++;
            $display("[TB] FAIL filler_cnt got %0d want 0", win_cnt);
        end
    endtask

    task automatic test_midstream_reset();
        doReset(1'b0);
        for (int i = 0; i < 17; i++) begin
            reset = (i == 6);
            en = (i == 0 || i == 6 || i == 8);
            pat_valid = (i == 1 || i == 4 || i == 9);
            pat_data  = (i == 4) ? 3'b101 : 3'b011;
            modelOutputs();
            nRun++;
            if ({pat_ready, s_out, w_out, res_valid, res_z, res_err} !== {expReady, expS, expW, expRv, expZ, expErr}) begin
                nFail++;
                $display("[TB] FAIL midrst_ctl cyc=%0d got %b want %b", i,
                         {pat_ready, s_out, w_out, res_valid, res_z, res_err}, {expReady, expS, expW, expRv, expZ, expErr});
            end
            nRun++;
            if (win_cnt !== 16'(winCnt) || err_cnt !== 16'(errCnt)) begin
                nFail++;
                $display("[TB] FAIL midrst_cnt cyc=%0d got %0d/%0d want %0d/%0d", i, win_cnt, err_cnt, winCnt, errCnt);
            end
            if (i == 7) begin
                nRun++;
                if ({pat_ready, s_out, res_valid} !== 3'b000 || win_cnt !== 16'd0) begin
                    nFail++;
                    $display("[TB] FAIL midrst_idle got r/s/v=%b win=%0d want 000 win=0", {pat_ready, s_out, res_valid}, win_cnt);
                end
            end
            if (i == 14) begin
                nRun++;
                if ({res_valid, res_z, res_err} !== 3'b110 || win_cnt !== 16'd1) begin
                    nFail++;
                    $display("[TB] FAIL midrst_restart got v/z/e=%b win=%0d want 110 win=1", {res_valid, res_z, res_err}, win_cnt);
                end
            end
            advance();
        end
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        forceZ0 = 1'b1;
        doReset(1'b0);
        for (int i = 0; i < 24; i++) begin
            en = (i == 0);
            pat_valid = (i >= 1 && i <= 13 && ((i - 1) % 3) == 0);
            pat_data  = 3'b110;
            modelOutputs();
            nRun++;
            if (satErrCnt !== 2'((errCnt > 3) ? 3 : errCnt) || satWin !== 2'((winCnt > 3) ? 3 : winCnt)) begin
                nFail++;
                $display("[TB] FAIL sat_cnt cyc=%0d got win=%0d err=%0d want win=%0d err=%0d", i, satWin, satErrCnt,
                         (winCnt > 3) ? 3 : winCnt, (errCnt > 3) ? 3 : errCnt);
            end
            advance();
        end
        nRun++;
        if (satErrCnt !== 2'd3 || err_cnt !== 16'd5) begin
            nFail++;
            $display("[TB] FAIL sat_final got satErr=%0d err=%0d want 3 and 5", satErrCnt, err_cnt);
        end
        forceZ0 = 1'b0;
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            forceZ0 = ($urandom % 3) == 0;
            doReset(1'b0);
            for (int i = 0; i < 45; i++) begin
                en        = (i == 0) || ($urandom % 2);
                pat_valid = ($urandom % 3) != 0;
                pat_data  = 3'($urandom);
                modelOutputs();
                nRun++;
                if ({pat_ready, s_out, w_out, res_valid, res_z, res_err} !== {expReady, expS, expW, expRv, expZ, expErr}) begin
                    nFail++;
                    $display("[TB] FAIL rand_ctl s=%0d cyc=%0d got %b want %b", s, i,
                             {pat_ready, s_out, w_out, res_valid, res_z, res_err}, {expReady, expS, expW, expRv, expZ, expErr});
                end
                nRun++;
                if (win_cnt !== 16'(winCnt) || err_cnt !== 16'(errCnt) ||
                    satErrCnt !== 2'((errCnt > 3) ? 3 : errCnt)) begin
                    nFail++;
                    $display("[TB] FAIL rand_cnt s=%0d cyc=%0d got %0d/%0d/%0d want %0d/%0d", s, i,
                             win_cnt, err_cnt, satErrCnt, winCnt, errCnt);
                end
                advance();
            end
        end
        forceZ0 = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; pat_valid = 1'b0; pat_data = 3'b000;
        @(posedge clk);
        #1;
        test_reset();
        test_single_window();
        test_back_to_back();
        test_fault();
        test_filler();
        test_midstream_reset();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout reached at cyc=%0d", cyc);
        $fatal(1, "[TB] timeout");
    end

endmodule
